// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: credit-limited fetch into a DEPTH-entry
// queue, with redirect flush and a drain phase for stale responses.
// Ports: clk_i, rst_i (async, active-high); imem_req_o/addr_o/gnt_i,
// imem_rvalid_i/rdata_i (memory side); redirect_i/redirect_pc_i;
// instruction_decode_o, pc_decode_o, valid_decode_o, ready_decode_i
// (decode side); misalign_o.
// Option: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects
// (misalign_o pulse, fetch stops until an aligned redirect); without it
// the low two redirect bits are ignored and misalign_o is tied low.
module prefetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic [31:0]      instruction_decode_o,
    output logic [WIDTH-1:0] pc_decode_o,
    output logic             valid_decode_o,
    input  logic             ready_decode_i,
    output logic             misalign_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    outst_q, outst_d, discard_q, discard_d;
    logic [31:0]      instr_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem [DEPTH];

    logic [CW-1:0]    occ;
    logic             empty, full, credit;
    logic             fire, pop, push, drop;
    logic [WIDTH-1:0] redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt_q, mis_q, redir_mis;

    assign redir_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halt_q <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            mis_q <= redir_mis;
            if (redirect_i) halt_q <= redir_mis;
        end
    end

    assign misalign_o = mis_q;
`else
    logic halt_q;

    assign halt_q     = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign redir_tgt = redirect_pc_i & ALIGN_MASK;

    // Pointers carry an extra wrap bit so full and empty differ.
    assign occ   = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                   (wptr_q[AW] != rptr_q[AW]);

    // Every outstanding request owns a queue slot before it is issued.
    assign credit = ({1'b0, occ} + {1'b0, outst_q}) < LIMIT;

    assign imem_req_o  = (state_q == RUN) && !halt_q && credit;
    assign imem_addr_o = fetch_pc_q;

    assign fire = imem_req_o && imem_gnt_i;
    assign drop = (discard_q != '0);
    assign pop  = valid_decode_o && ready_decode_i && !redirect_i;
    assign push = imem_rvalid_i && !drop && !redirect_i && !full;

    assign valid_decode_o       = !empty;
    assign instruction_decode_o = empty ? '0 : instr_mem[rptr_q[AW-1:0]];
    assign pc_decode_o          = empty ? '0 : pc_mem[rptr_q[AW-1:0]];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wptr_d     = wptr_q + CW'(push);
        rptr_d     = rptr_q + CW'(pop);
        outst_d    = outst_q + CW'(fire) - CW'(imem_rvalid_i);
        discard_d  = discard_q - CW'(imem_rvalid_i && drop);

        if (fire) fetch_pc_d = fetch_pc_q + WIDTH'(4);
        if (push) resp_pc_d = resp_pc_q + WIDTH'(4);

        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            DRAIN:   if (discard_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase

        // Everything still in flight (including a same-cycle grant)
        // belongs to the old stream; a same-cycle response is dropped.
        if (redirect_i) begin
            rptr_d     = wptr_q;
            fetch_pc_d = redir_tgt;
            resp_pc_d  = redir_tgt;
            discard_d  = outst_d;
            state_d    = (outst_d != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wptr_q     <= '0;
            rptr_q     <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wptr_q[AW-1:0]] <= imem_rdata_i;
            pc_mem[wptr_q[AW-1:0]]    <= resp_pc_q;
        end
    end

endmodule
